// File: rtl/barrett_rr_sched_if.sv
// Bundle between barrett_rr_sched and its requesters, consumer, config master and reduction datapath.
// master = the surrounding system, slave = the scheduler.
interface barrett_rr_sched_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 64
);
   localparam int IDW = $clog2(N_REQ);

   logic                   cfg_we;
   logic [WIDTH-1:0]       cfg_m;
   logic [WIDTH-1:0]       cfg_mu;
   logic                   cfg_ack;
   logic                   cfg_valid;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_x;
   logic [N_REQ-1:0]       req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [WIDTH-1:0]       rsp_r;
   logic                   busy;
   logic [WIDTH-1:0]       dp_x;
   logic [WIDTH-1:0]       dp_m;
   logic [WIDTH-1:0]       dp_mu;
   logic [WIDTH-1:0]       dp_m_bl;
   logic [WIDTH-1:0]       dp_r;
   logic                   err;

   modport master (
      output cfg_we, cfg_m, cfg_mu, req_valid, req_x, rsp_ready, dp_r,
      input  cfg_ack, cfg_valid, req_ready, rsp_valid, rsp_id, rsp_r, busy,
             dp_x, dp_m, dp_mu, dp_m_bl, err
   );

   modport slave (
      input  cfg_we, cfg_m, cfg_mu, req_valid, req_x, rsp_ready, dp_r,
      output cfg_ack, cfg_valid, req_ready, rsp_valid, rsp_id, rsp_r, busy,
             dp_x, dp_m, dp_mu, dp_m_bl, err
   );
endinterface

// File: rtl/barrett_rr_sched.sv
// Round-robin scheduler sharing one Barrett reduction datapath among N_REQ requesters.
// Optional feature: define BARRETT_RR_SCHED_RANGE_CHECK_EN for result range correction and sticky err.
module barrett_rr_sched #(
   parameter int N_REQ  = 4,
   parameter int WIDTH  = 64,
   parameter int DP_LAT = 1
) (
   input logic               clk_i,
   input logic               rst_i,
   barrett_rr_sched_if.slave bus
);
   localparam int IDW = $clog2(N_REQ);
   localparam int LW  = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   id;
   logic [LW-1:0]    lat_cnt;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] mu;
   logic [WIDTH-1:0] m_bl;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] res;
   logic             cfg_ack;
   logic             cfg_valid;
   logic             cfg_ok;
   logic             gnt_any;
   logic [IDW-1:0]   gnt_idx;
   logic             grant_en;
   int               idx;

   // ceil(log2(v)) for v >= 2 is the bit length of v-1
   function automatic logic [WIDTH-1:0] ceil_log2(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] t;
      ceil_log2 = '0;
      t = v - WIDTH'(1);
      for (int i = 0; i < WIDTH; i++)
         if (t[i]) ceil_log2 = WIDTH'(i + 1);
   endfunction

`ifdef BARRETT_RR_SCHED_RANGE_CHECK_EN
   logic err;

   function automatic logic [WIDTH-1:0] range_fix(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] mod);
      range_fix = (r >= mod) ? (r - mod) : r;
   endfunction
`endif

   assign cfg_ok = bus.cfg_we && (bus.cfg_m >= WIDTH'(2));

   // Search from last_grant+1 upward, wrapping; the first valid requester wins
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(last_grant) + i) % N_REQ;
         if (!gnt_any && bus.req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
   end

   assign grant_en      = (state == IDLE) && cfg_valid && !cfg_ok && gnt_any;
   assign bus.req_ready = grant_en ? (N_REQ'(1) << gnt_idx) : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= IDW'(N_REQ - 1);
         id         <= '0;
         lat_cnt    <= '0;
         m          <= '0;
         mu         <= '0;
         m_bl       <= '0;
         x          <= '0;
         res        <= '0;
         cfg_ack    <= 1'b0;
         cfg_valid  <= 1'b0;
`ifdef BARRETT_RR_SCHED_RANGE_CHECK_EN
         err        <= 1'b0;
`endif
      end else begin
         cfg_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_ok) begin
                  m         <= bus.cfg_m;
                  mu        <= bus.cfg_mu;
                  m_bl      <= ceil_log2(bus.cfg_m);
                  cfg_valid <= 1'b1;
                  cfg_ack   <= 1'b1;
               end else if (grant_en) begin
                  x          <= bus.req_x[gnt_idx*WIDTH +: WIDTH];
                  id         <= gnt_idx;
                  last_grant <= gnt_idx;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt <= LW'(DP_LAT - 1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == '0) begin
`ifdef BARRETT_RR_SCHED_RANGE_CHECK_EN
                  res <= range_fix(bus.dp_r, m);
                  if (bus.dp_r >= m) err <= 1'b1;
`else
                  res <= bus.dp_r;
`endif
                  state <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - LW'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cfg_ack   = cfg_ack;
   assign bus.cfg_valid = cfg_valid;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = id;
   assign bus.rsp_r     = res;
   assign bus.busy      = (state != IDLE);
   assign bus.dp_x      = x;
   assign bus.dp_m      = m;
   assign bus.dp_mu     = mu;
   assign bus.dp_m_bl   = m_bl;
`ifdef BARRETT_RR_SCHED_RANGE_CHECK_EN
   assign bus.err       = err;
`else
   assign bus.err       = 1'b0;
`endif
endmodule
